// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer:
// funct3 op codes, FSM state encoding and op-class predicates.
package muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Divide/remainder ops all have funct3[2] set
    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // rs1 is treated as signed
    function automatic logic a_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is treated as signed
    function automatic logic b_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage handshake between the pipeline and the multiply/divide sequencer.
interface muldiv_sequencer_if #(
    parameter int unsigned BITS = 32
) ();
    logic            Start;
    logic [2:0]      Op;
    logic [BITS-1:0] OperandA;
    logic [BITS-1:0] OperandB;
    logic            Flush;
    logic            Stall;
    logic            Busy;
    logic            Done;
    logic [BITS-1:0] Result;

    modport master (
        output Start, Op, OperandA, OperandB, Flush,
        input  Stall, Busy, Done, Result
    );

    modport slave (
        input  Start, Op, OperandA, OperandB, Flush,
        output Stall, Busy, Done, Result
    );
endinterface

// File: rtl/muldiv_iter_step.sv
// One radix-2 iteration on the shared 2*BITS accumulator.
// Multiply: acc = {partial high, remaining multiplier}; add-then-shift-right.
// Divide:   acc = {partial remainder, dividend/quotient}; shift-left, trial-subtract.
module muldiv_iter_step #(
    parameter int unsigned BITS = 32
) (
    input  logic              div_i,
    input  logic [2*BITS-1:0] acc_i,
    input  logic [BITS-1:0]   b_i,
    output logic [2*BITS-1:0] acc_o
);

    logic [BITS:0]   sum;
    logic [BITS:0]   rem_sh;
    logic [BITS-1:0] trial;
    logic            fits;

    // Single add/shift or shift/subtract step
    always_comb begin
        sum    = {1'b0, acc_i[2*BITS-1:BITS]} + (acc_i[0] ? {1'b0, b_i} : '0);
        rem_sh = {acc_i[2*BITS-1:BITS], acc_i[BITS-1]};
        fits   = (rem_sh >= {1'b0, b_i});
        // When it fits the difference is below the divisor, so BITS bits suffice
        trial  = rem_sh[BITS-1:0] - b_i;
        if (div_i) begin
            acc_o = {(fits ? trial : rem_sh[BITS-1:0]), acc_i[BITS-2:0], fits};
        end else begin
            acc_o = {sum, acc_i[BITS-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: iterative shift-add multiply and restoring
// divide over BITS cycles, with divide special cases resolved in one cycle.
// Optional macro MULDIV_REUSE_EN: reuse the last iterated divide's
// quotient/remainder when the same operands come again.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned BITS  = 32,
    parameter int unsigned CNT_W = $clog2(BITS)
) (
    input logic               clk,
    input logic               rst,
    muldiv_sequencer_if.slave bus
);

    localparam logic [BITS-1:0]  MIN_NEG = {1'b1, {(BITS-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(BITS - 1);

    md_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        op_q;
    logic [2*BITS-1:0] acc_q;
    logic [BITS-1:0]   b_q;
    logic              neg_q_q;
    logic              neg_r_q;
    logic [BITS-1:0]   pend_q;
    logic [BITS-1:0]   res_q;

    logic              accept;
    logic              sa, sb;
    logic [BITS-1:0]   a_mag, b_mag;
    logic              special;
    logic [BITS-1:0]   sp_res;
    logic              hit;
    logic [BITS-1:0]   hit_res;
    logic [2*BITS-1:0] acc_nxt;
    logic [2*BITS-1:0] prod_fix;
    logic [BITS-1:0]   quo_fix, rem_fix;
    logic [BITS-1:0]   fin_res;

`ifdef MULDIV_REUSE_EN
    logic              c_valid_q;
    logic [BITS-1:0]   c_a_q, c_b_q;
    logic              c_sgn_q;
    logic [BITS-1:0]   c_quo_q, c_rem_q;
    logic [BITS-1:0]   a_raw_q, b_raw_q;
`endif

    muldiv_iter_step #(.BITS(BITS)) u_step (
        .div_i (is_div(op_q)),
        .acc_i (acc_q),
        .b_i   (b_q),
        .acc_o (acc_nxt)
    );

    // Accept-cycle decode: magnitudes, signs and one-cycle special cases
    always_comb begin
        accept  = bus.Start && !bus.Flush;
        sa      = a_signed(bus.Op) && bus.OperandA[BITS-1];
        sb      = b_signed(bus.Op) && bus.OperandB[BITS-1];
        a_mag   = sa ? ('0 - bus.OperandA) : bus.OperandA;
        b_mag   = sb ? ('0 - bus.OperandB) : bus.OperandB;
        special = 1'b0;
        sp_res  = '0;
        if (is_div(bus.Op) && (bus.OperandB == '0)) begin
            special = 1'b1;
            sp_res  = bus.Op[1] ? bus.OperandA : '1;
        end else if (is_div(bus.Op) && b_signed(bus.Op) &&
                     (bus.OperandA == MIN_NEG) && (bus.OperandB == '1)) begin
            special = 1'b1;
            sp_res  = bus.Op[1] ? '0 : bus.OperandA;
        end
`ifdef MULDIV_REUSE_EN
        hit     = is_div(bus.Op) && c_valid_q && (bus.OperandA == c_a_q) &&
                  (bus.OperandB == c_b_q) && (c_sgn_q == a_signed(bus.Op));
        hit_res = bus.Op[1] ? c_rem_q : c_quo_q;
`else
        hit     = 1'b0;
        hit_res = '0;
`endif
    end

    // Final-iteration sign correction and result select
    always_comb begin
        prod_fix = neg_q_q ? ('0 - acc_nxt) : acc_nxt;
        quo_fix  = neg_q_q ? ('0 - acc_nxt[BITS-1:0]) : acc_nxt[BITS-1:0];
        rem_fix  = neg_r_q ? ('0 - acc_nxt[2*BITS-1:BITS]) : acc_nxt[2*BITS-1:BITS];
        case (op_q)
            MD_MUL:                       fin_res = prod_fix[BITS-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fin_res = prod_fix[2*BITS-1:BITS];
            MD_DIV, MD_DIVU:              fin_res = quo_fix;
            MD_REM, MD_REMU:              fin_res = rem_fix;
            default:                      fin_res = '0;
        endcase
    end

    // Sequencer FSM with operand, accumulator and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            pend_q    <= '0;
            res_q     <= '0;
`ifdef MULDIV_REUSE_EN
            c_valid_q <= 1'b0;
            c_a_q     <= '0;
            c_b_q     <= '0;
            c_sgn_q   <= 1'b0;
            c_quo_q   <= '0;
            c_rem_q   <= '0;
            a_raw_q   <= '0;
            b_raw_q   <= '0;
`endif
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (accept) begin
                        op_q    <= bus.Op;
                        acc_q   <= {{BITS{1'b0}}, a_mag};
                        b_q     <= b_mag;
                        neg_q_q <= sa ^ sb;
                        neg_r_q <= sa;
                        cnt_q   <= '0;
`ifdef MULDIV_REUSE_EN
                        a_raw_q <= bus.OperandA;
                        b_raw_q <= bus.OperandB;
`endif
                        if (special) begin
                            pend_q  <= sp_res;
                            state_q <= MD_DONE;
                        end else if (hit) begin
                            pend_q  <= hit_res;
                            state_q <= MD_DONE;
                        end else begin
                            state_q <= MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    if (bus.Flush) begin
                        state_q   <= MD_IDLE;
                        cnt_q     <= '0;
`ifdef MULDIV_REUSE_EN
                        c_valid_q <= 1'b0;
`endif
                    end else begin
                        acc_q <= acc_nxt;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            pend_q  <= fin_res;
                            state_q <= MD_DONE;
`ifdef MULDIV_REUSE_EN
                            if (is_div(op_q)) begin
                                c_valid_q <= 1'b1;
                                c_a_q     <= a_raw_q;
                                c_b_q     <= b_raw_q;
                                c_sgn_q   <= a_signed(op_q);
                                c_quo_q   <= quo_fix;
                                c_rem_q   <= rem_fix;
                            end
`endif
                        end
                    end
                end
                MD_DONE: begin
                    state_q <= MD_IDLE;
                    if (!bus.Flush) begin
                        res_q <= pend_q;
                    end
`ifdef MULDIV_REUSE_EN
                    else begin
                        c_valid_q <= 1'b0;
                    end
`endif
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    // New result sits in pend_q during DONE and is committed to res_q only if
    // not flushed, so a flush in DONE hides both Done and the new value.
    assign bus.Stall  = ((state_q == MD_IDLE) && accept) || (state_q == MD_CALC);
    assign bus.Busy   = (state_q != MD_IDLE);
    assign bus.Done   = (state_q == MD_DONE) && !bus.Flush;
    assign bus.Result = bus.Done ? pend_q : res_q;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide operations.
- Sits beside the ALU in the EX stage. Accepts one M-extension operation, runs an iterative radix-2 shift-add multiply or restoring divide over BITS cycles, and holds the pipeline with Stall until the result is ready.
- Resolves RISC-V divide special cases (divide-by-zero, signed overflow) without iterating.

Parameters:
- BITS, 32, operand/result width (must be >= 4).
- CNT_W, $clog2(BITS), iteration counter width.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst  input  1  synchronous active-high reset.
- Start  input  1  EX stage holds a valid M-extension op; held high by the stalled pipeline until Done.
- Op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- OperandA  input  BITS  rs1 value; sampled only on the accept cycle.
- OperandB  input  BITS  rs2 value; sampled only on the accept cycle.
- Flush  input  1  branch/jump squash; aborts the current operation.
- Stall  output  1  freeze PC and IF/ID/EX registers.
- Busy  output  1  state != IDLE.
- Done  output  1  one-cycle pulse; Result valid.
- Result  output  BITS  registered result.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset values: state IDLE, counter 0, Done 0, Result 0, Busy 0, Stall 0, all internal operand/accumulator registers 0. Reset mid-operation discards it and produces no Done.
- States: IDLE, CALC, DONE.
- IDLE:
  - Accept when Start & !Flush.
  - On accept, latch the op and operand magnitudes. Signedness: A is signed for MULH/MULHSU/DIV/REM; B is signed for MULH/DIV/REM.
  - Latch result signs: negP = sA^sB; quotient sign sA^sB; remainder sign sA.
  - Special case B==0 on a divide op: DIV/DIVU result all ones; REM/REMU result OperandA. Go to DONE.
  - Special case signed overflow, DIV/REM with A = -2^(BITS-1) and B = -1: DIV result A; REM result 0. Go to DONE.
  - Otherwise go to CALC with counter 0.
- CALC:
  - One iteration per cycle, BITS iterations.
  - Multiply: 2*BITS-bit product; the multiplier bit is consumed LSB-first.
  - Divide: restoring; shift the remainder left with the dividend MSB, then trial-subtract the divisor.
  - At counter == BITS-1, go to DONE.
- DONE:
  - Apply sign correction (two's-complement negate) and select the output: MUL takes the low half; MULH/MULHSU/MULHU take the high half; quotient or remainder for divides.
  - Register Result and pulse Done for 1 cycle, then go to IDLE.
  - Start is ignored in DONE.
- Latency:
  - Start accepted in cycle t → Done in cycle t+BITS+1.
  - Special cases → Done in cycle t+1.
- Stall = (IDLE & Start & !Flush) | CALC. Stall is 0 in DONE so the pipeline advances on the Done edge.
- Flush in CALC or DONE:
  - Go to IDLE next cycle; Done is suppressed; Result keeps its previous value.
  - Flush wins over Start in IDLE.
- Result holds its value between operations.

Optional Feature:
- Macro MULDIV_REUSE_EN.
- When defined:
  - After any iterated divide, keep {A, B, signedness, quotient, remainder}, already sign-corrected, plus a valid bit.
  - A subsequent DIV/DIVU/REM/REMU with identical operands and signedness goes IDLE→DONE, giving Done in t+1.
  - The valid bit is cleared by rst and by Flush-abort.
- When undefined: no cache; every non-special op takes full latency.

Decomposition:
- Shared package muldiv_pkg:
  - Op localparams MD_MUL..MD_REMU.
  - State encoding MD_IDLE/MD_CALC/MD_DONE.
  - Helper predicates is_div(op), a_signed(op), b_signed(op).
- One sub-module, muldiv_iter_step: combinational single-iteration add/shift-subtract on the accumulator. It is instanced once and keeps the FSM file control-only.

Test Plan (BITS=32):
- MUL A=7, B=0xFFFFFFFD, Start at cycle t → Stall high t..t+32, Done at t+33, Result 0xFFFFFFEB.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU same operands → 0x40000000; MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; each Done at t+33.
- Special cases, Done at t+1 and Stall high only in t:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- Abort and reset:
  - Flush at CALC iteration 10 → IDLE next cycle, no Done, Stall low, Result unchanged; a following DIVU 100/7 gives 14 at full latency.
  - rst mid-CALC → all outputs at reset values the next cycle.
- Reuse feature: DIV 100/7 followed by REM 100/7 → REM gives 2 with Done at t+1 when MULDIV_REUSE_EN is defined, and at t+33 when it is not.
